// File: rtl/data_mem_unit_if.sv
// rtl/data_mem_unit_if.sv - request/response bundle between the ALU load/store path and data_mem_unit
//
// Purpose: groups the valid/ready request channel and the response pulse of
// the data memory stage so that both ends connect through a single port.
// Signals:
//   req_valid  request present (master -> slave)
//   req_ready  slave can accept a request (slave -> master)
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_be     store byte enables, lane i = byte addr+i
//   req_wdata  store bytes, lane i -> byte addr+i
//   rsp_valid  one-cycle completion pulse
//   rsp_rdata  load bytes, lane i = byte addr+i; 0 for stores
interface data_mem_unit_if;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [31:0]     req_addr;
  logic [3:0]      req_be;
  logic [3:0][7:0] req_wdata;
  logic            rsp_valid;
  logic [3:0][7:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - byte-addressable word-organised data memory with split unaligned accesses
//
// Purpose: serves loads and stores from the ALU. Accesses whose bytes span
// two words are performed as two sequential word accesses (word w on the
// handshake edge, word w+1 on the SECOND edge), then a one-cycle response.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (storage is not cleared)
//   bus    data_mem_unit_if.slave: req_valid/req_ready/req_we/req_addr/
//          req_be/req_wdata in, rsp_valid/rsp_rdata out
module data_mem_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SECOND = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state;
  logic            ready_q;
  logic            rsp_valid_q;
  logic [3:0][7:0] rsp_rdata_q;

  // Captured request
  logic            we_q;
  logic [3:0]      be_q;
  logic [3:0][7:0] wdata_q;
  logic [1:0]      off_q;
  logic [AW-1:0]   w_q;

  // Word w as read on the handshake edge of a crossing load
  logic [3:0][7:0] hold_q;

  logic [3:0][7:0] mem [DEPTH_WORDS];

  logic            handshake;
  logic [1:0]      off_in;
  logic [AW-1:0]   w_in;
  logic [AW-1:0]   w_next_q;
  logic [3:0][2:0] pos_in;
  logic [3:0][2:0] pos_q;
  logic [3:0]      hi_in;
  logic            cross_in;
  logic            unused_addr;

  assign handshake   = bus.req_valid && ready_q;
  assign off_in      = bus.req_addr[1:0];
  assign w_in        = bus.req_addr[AW+1:2];
  // Natural AW-bit overflow gives the wrap from DEPTH_WORDS-1 to 0
  assign w_next_q    = w_q + AW'(1);
  // Upper address bits alias the space and are intentionally dropped
  assign unused_addr = ^bus.req_addr[31:AW+2];

  // pos = off + lane: bit 2 selects word w+1, bits 1:0 give the byte in that word
  always_comb begin
    pos_in = '0;
    pos_q  = '0;
    hi_in  = '0;
    for (int i = 0; i < 4; i++) begin
      pos_in[i] = {1'b0, off_in} + 3'(i);
      pos_q[i]  = {1'b0, off_q} + 3'(i);
      hi_in[i]  = pos_in[i][2];
    end
  end

  // Stores only cross if an enabled lane lands in w+1; loads always need all four bytes
  assign cross_in = bus.req_we ? |(bus.req_be & hi_in) : (off_in != 2'd0);

  function automatic logic [3:0][7:0] assemble(input logic [3:0][7:0] lo,
                                               input logic [3:0][7:0] hi,
                                               input logic [1:0]      off);
    logic [3:0][7:0] r;
    logic [2:0]      p;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      p    = {1'b0, off} + 3'(i);
      r[i] = p[2] ? hi[p[1:0]] : lo[p[1:0]];
    end
    return r;
  endfunction

  // Storage has no reset; writes are gated by rst_n so that a reset landing
  // in SECOND suppresses the w+1 half while the w half already done stays.
  always_ff @(posedge clk) begin
    if (rst_n && handshake && bus.req_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_be[i] && !pos_in[i][2]) begin
          mem[w_in][pos_in[i][1:0]] <= bus.req_wdata[i];
        end
      end
    end
    if (rst_n && (state == SECOND) && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i] && pos_q[i][2]) begin
          mem[w_next_q][pos_q[i][1:0]] <= wdata_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      off_q       <= '0;
      w_q         <= '0;
      hold_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            we_q    <= bus.req_we;
            be_q    <= bus.req_be;
            wdata_q <= bus.req_wdata;
            off_q   <= off_in;
            w_q     <= w_in;
            hold_q  <= mem[w_in];
            ready_q <= 1'b0;
            if (cross_in) begin
              state <= SECOND;
            end else begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              // A non-crossing load is word aligned, so word w is the answer
              rsp_rdata_q <= bus.req_we ? '0 : mem[w_in];
            end
          end
        end
        SECOND: begin
          state       <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= we_q ? '0 : assemble(hold_q, mem[w_next_q], off_q);
        end
        RESP: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Byte-addressable data memory stage directly downstream of the ALU's load/store path.
- Consumes the effective address, write enable and 4-byte lane data the ALU produces; returns the 4-byte read lanes the ALU uses for load extension.
- Storage is word-organised. An access that crosses a word boundary is split into two sequential word accesses, sequenced by a small FSM with a valid/ready request and a one-cycle response pulse.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words of storage; power of two.
- AW, 10: word-index width, equal to log2(DEPTH_WORDS).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_be  in  4  store byte enables, lane i = byte addr+i; ignored for loads
- req_wdata  in  8 x4  store bytes, lane i -> byte addr+i
- rsp_valid  out  1  one-cycle completion pulse, for loads and stores
- rsp_rdata  out  8 x4  load bytes, lane i = byte at addr+i; 0 for stores

Behaviour:
- Addressing:
  - off = req_addr[1:0]; w = req_addr[AW+1:2].
  - Upper address bits are ignored, so the address space aliases modulo DEPTH_WORDS*4.
  - w+1 wraps to 0 at DEPTH_WORDS-1.
- Crossing rule:
  - A load crosses when off != 0.
  - A store crosses when some req_be[i]=1 with i >= 4-off.
  - Lane i maps to word w, byte off+i when off+i <= 3; otherwise to word w+1, byte off+i-4.
- Request capture: on req_valid && req_ready, register we, be, wdata, off, w. Inputs are don't-care at all other times.
- FSM states: IDLE, SECOND, RESP.
  - IDLE -> SECOND on handshake when the access crosses.
  - IDLE -> RESP on handshake when it does not cross.
  - SECOND -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- Cycle 0 (handshake edge):
  - Store: writes the enabled lanes that map to word w.
  - Load: captures word w into a holding register.
- SECOND edge:
  - Store: writes the enabled lanes that map to word w+1.
  - Load: captures word w+1.
- Response:
  - rsp_valid=1 for exactly the cycle the FSM is in RESP.
  - Latency from handshake cycle: 1 cycle for non-crossing, 2 cycles for crossing.
  - req_ready=1 again the cycle after RESP.
  - No response backpressure.
- rsp_rdata:
  - Registered and assembled per the lane mapping. Lanes whose mapped byte is in w+1 are taken from the second read.
  - Holds its value outside RESP; cleared to 0 on store responses.
- Byte enables: lanes with req_be[i]=0 are never written. A store with be=0000 still completes with latency 1.
- Ordering: a new request is accepted only from IDLE, so a load always observes every earlier store.
- Throughput: one request per 2 cycles non-crossing, per 3 cycles crossing.
- Reset (rst_n low, any time):
  - FSM returns to IDLE; rsp_valid=0, rsp_rdata=0, req_ready=1 immediately.
  - Storage is not cleared.
  - If reset is asserted while in SECOND, the w+1 write is not performed. The w write already done stays.
  - No response is produced for the aborted request.
- Simultaneous events: req_valid held high while busy is ignored until IDLE. It is then accepted in the first IDLE cycle.

Test Plan:
- Aligned word: store addr 0x100, be=1111, wdata {EF,BE,AD,DE}; then load 0x100. Required: each response arrives 1 cycle after its handshake; load rdata lanes {EF,BE,AD,DE}; req_ready low during RESP.
- Partial store: preload 0x200 = 11223344; store addr 0x202, be=0011, lanes {AA,BB}; load 0x200. Required: word reads 0xBBAA3344; response latency 1.
- Crossing store/load: store addr 0x103, be=1111, wdata {01,02,03,04}. Required: FSM passes through SECOND; rsp_valid 2 cycles after handshake; byte 0x103=01 and bytes 0x104..0x106=02,03,04. Load 0x103 returns {01,02,03,04} with latency 2.
- Wrap-around, DEPTH_WORDS=1024: store addr 0xFFE, be=1111, wdata {A1,A2,A3,A4}. Required: bytes 0xFFE..0xFFF = A1,A2 and bytes 0x000..0x001 = A3,A4. A load from 0x1000 returns 0x000's word (alias).
- Reset mid-crossing: start crossing store at 0x1FE with 0x200 preloaded 0; assert rst_n=0 during SECOND. Required: no rsp_valid; 0x200 unchanged; bytes 0x1FE..0x1FF written; req_ready=1 during reset.
- Busy hold-off: hold req_valid=1 across two back-to-back non-crossing loads. Required: handshakes 2 cycles apart; no request is lost or accepted twice.
